// File: rtl/aa_pkg.sv
// Shared constants and arithmetic helpers for the anti-alias boxcar filter.
package aa_pkg;

    localparam int BOXCAR_LEN = 4;
    localparam int WIDE_W     = 48;

    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int growth(input int order);
        return 2 * order;
    endfunction

    function automatic int fill_cycles(input int order);
        return 6 * order + 1;
    endfunction

    function automatic int latency(input int order);
        return 3 * order + 1;
    endfunction

    // Bit offset of segment k in a flattened stage chain whose segment k is width+2k bits wide.
    function automatic int chain_offset(input int width, input int k);
        return k * width + k * (k - 1);
    endfunction

    function automatic wide_t round_half_up(input wide_t v, input int sh);
        return (v + (wide_t'(1) <<< (sh - 1))) >>> sh;
    endfunction

    function automatic wide_t saturate(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/aa_filter_boxcar4_stage.sv
// Single-rail pipelined length-4 moving sum; output is 2 bits wider than input, 3 edges of latency.
module boxcar4_stage
    import aa_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] din,
    output logic signed [IN_W+1:0] dout
);

    logic signed [IN_W-1:0] tap [BOXCAR_LEN];
    logic signed [IN_W:0]   p01;
    logic signed [IN_W:0]   p23;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BOXCAR_LEN; i++) tap[i] <= '0;
            p01  <= '0;
            p23  <= '0;
            dout <= '0;
        end else begin
            tap[0] <= din;
            for (int i = 1; i < BOXCAR_LEN; i++) tap[i] <= tap[i-1];
            // Pairwise partial sums keep each adder one level deep at 40 MHz.
            p01  <= (IN_W+1)'(tap[0]) + (IN_W+1)'(tap[1]);
            p23  <= (IN_W+1)'(tap[2]) + (IN_W+1)'(tap[3]);
            dout <= (IN_W+2)'(p01) + (IN_W+2)'(p23);
        end
    end

endmodule

// File: rtl/aa_filter.sv
// Anti-alias filter: ORDER cascaded length-4 boxcars on I and Q, round and saturate to WIDTH.
// Optional macro AA_BYPASS_EN adds a latency-matched bypass path selected by the bypass port.
module aa_filter
    import aa_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int ORDER = 2
) (
    input  logic                    clk_40mhz,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] data_in_I,
    input  logic signed [WIDTH-1:0] data_in_Q,
    output logic signed [WIDTH-1:0] data_out_I,
    output logic signed [WIDTH-1:0] data_out_Q,
`ifdef AA_BYPASS_EN
    input  logic                    bypass,
`endif
    output logic                    out_valid
);

    localparam int GROW    = growth(ORDER);
    localparam int IW      = WIDTH + GROW;
    localparam int FILL    = fill_cycles(ORDER);
    localparam int LAT     = latency(ORDER);
    localparam int CNT_W   = $clog2(FILL + 1);
    localparam int CHAIN_W = chain_offset(WIDTH, ORDER + 1);
    localparam int OFF_OUT = chain_offset(WIDTH, ORDER);

    // Segment k of each chain is the input of stage k (WIDTH+2k bits); the last segment is the filter sum.
    logic [CHAIN_W-1:0] chain_i;
    logic [CHAIN_W-1:0] chain_q;

    assign chain_i[WIDTH-1:0] = data_in_I;
    assign chain_q[WIDTH-1:0] = data_in_Q;

    for (genvar k = 0; k < ORDER; k++) begin : g_stage
        localparam int SW   = WIDTH + 2 * k;
        localparam int OFF  = chain_offset(WIDTH, k);
        localparam int NOFF = chain_offset(WIDTH, k + 1);

        boxcar4_stage #(.IN_W(SW)) u_stage_i (
            .clk  (clk_40mhz),
            .rst  (rst),
            .din  (chain_i[OFF +: SW]),
            .dout (chain_i[NOFF +: SW+2])
        );

        boxcar4_stage #(.IN_W(SW)) u_stage_q (
            .clk  (clk_40mhz),
            .rst  (rst),
            .din  (chain_q[OFF +: SW]),
            .dout (chain_q[NOFF +: SW+2])
        );
    end

    wide_t rnd_i;
    wide_t rnd_q;
    wide_t sat_i;
    wide_t sat_q;
    logic  sat_hit;

    always_comb begin
        rnd_i   = round_half_up(wide_t'($signed(chain_i[OFF_OUT +: IW])), GROW);
        rnd_q   = round_half_up(wide_t'($signed(chain_q[OFF_OUT +: IW])), GROW);
        sat_i   = saturate(rnd_i, WIDTH);
        sat_q   = saturate(rnd_q, WIDTH);
        sat_hit = (sat_i != rnd_i) || (sat_q != rnd_q);
    end

    // Unity DC gain means the clamp can never engage; firing indicates an arithmetic bug.
    sat_unreachable: assert property (@(posedge clk_40mhz) disable iff (rst) !sat_hit);

    logic signed [WIDTH-1:0] next_i;
    logic signed [WIDTH-1:0] next_q;

`ifdef AA_BYPASS_EN
    // LAT-1 delay registers plus the output register give the same latency as the filter path.
    logic signed [WIDTH-1:0] dly_i [LAT-1];
    logic signed [WIDTH-1:0] dly_q [LAT-1];

    always_ff @(posedge clk_40mhz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT - 1; i++) begin
                dly_i[i] <= '0;
                dly_q[i] <= '0;
            end
        end else begin
            dly_i[0] <= data_in_I;
            dly_q[0] <= data_in_Q;
            for (int i = 1; i < LAT - 1; i++) begin
                dly_i[i] <= dly_i[i-1];
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    always_comb begin
        next_i = bypass ? dly_i[LAT-2] : sat_i[WIDTH-1:0];
        next_q = bypass ? dly_q[LAT-2] : sat_q[WIDTH-1:0];
    end
`else
    always_comb begin
        next_i = sat_i[WIDTH-1:0];
        next_q = sat_q[WIDTH-1:0];
    end
`endif

    logic [CNT_W-1:0] fill_cnt;

    always_ff @(posedge clk_40mhz or posedge rst) begin
        if (rst) begin
            data_out_I <= '0;
            data_out_Q <= '0;
            fill_cnt   <= '0;
        end else begin
            data_out_I <= next_i;
            data_out_Q <= next_q;
            if (fill_cnt != CNT_W'(FILL)) fill_cnt <= fill_cnt + CNT_W'(1);
        end
    end

    // Combinational from the counter so that an asynchronous reset drops out_valid at once.
    assign out_valid = (fill_cnt == CNT_W'(FILL));

endmodule

// File: tb/tb_aa_filter.sv
// Directed bench for aa_filter (ORDER=2): vector table for impulse/fill, hand sequences for corners.
module tb_aa_filter;

    logic                clk;
    logic                rst;
    logic signed [13:0]  in_i;
    logic signed [13:0]  in_q;
    logic signed [13:0]  out_i;
    logic signed [13:0]  out_q;
    logic                out_valid;
`ifdef AA_BYPASS_EN
    logic                bypass;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic sat_seen = 1'b0;

    aa_filter #(.WIDTH(14), .ORDER(2)) dut (
        .clk_40mhz  (clk),
        .rst        (rst),
        .data_in_I  (in_i),
        .data_in_Q  (in_q),
        .data_out_I (out_i),
        .data_out_Q (out_q),
`ifdef AA_BYPASS_EN
        .bypass     (bypass),
`endif
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && dut.sat_hit) sat_seen = 1'b1;

    typedef struct {
        logic signed [13:0] in_i;
        logic signed [13:0] in_q;
        logic signed [13:0] exp_i;
        logic signed [13:0] exp_q;
        logic               exp_v;
    } vec_t;

    vec_t vt[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        in_i = '0;
        in_q = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int imp_i[7] = '{63, 125, 188, 250, 188, 125, 63};
        int imp_q[7] = '{-62, -125, -187, -250, -187, -125, -62};
        int exp;

        rst  = 1'b1;
        in_i = '0;
        in_q = '0;
`ifdef AA_BYPASS_EN
        bypass = 1'b0;
`endif

        // Impulse table: I impulse captured at edge 1, Q impulse at edge 3.
        for (int j = 0; j < 18; j++) begin
            vt[j].in_i  = (j == 0) ? 14'sd1000 : 14'sd0;
            vt[j].in_q  = (j == 2) ? -14'sd1000 : 14'sd0;
            vt[j].exp_i = (j >= 6 && j <= 12) ? 14'(imp_i[j-6]) : 14'sd0;
            vt[j].exp_q = (j >= 8 && j <= 14) ? 14'(imp_q[j-8]) : 14'sd0;
            vt[j].exp_v = (j >= 12);
        end

        // Reset held with random inputs.
        for (int j = 0; j < 4; j++) begin
            in_i = 14'($urandom_range(16383, 0));
            in_q = 14'($urandom_range(16383, 0));
            tick();
            check($sformatf("rst_out_i[%0d]", j), int'(out_i), 0);
            check($sformatf("rst_out_q[%0d]", j), int'(out_q), 0);
            check($sformatf("rst_valid[%0d]", j), int'(out_valid), 0);
        end
        rst = 1'b0;

        for (int j = 0; j < 18; j++) begin
            in_i = vt[j].in_i;
            in_q = vt[j].in_q;
            tick();
            check($sformatf("imp_i[edge %0d]", j + 1), int'(out_i), int'(vt[j].exp_i));
            check($sformatf("imp_q[edge %0d]", j + 1), int'(out_q), int'(vt[j].exp_q));
            check($sformatf("imp_valid[edge %0d]", j + 1), int'(out_valid), int'(vt[j].exp_v));
        end

        // DC extremes pass through exactly at unity gain.
        apply_reset();
        for (int e = 1; e <= 20; e++) begin
            in_i = 14'sd8191;
            in_q = -14'sd8192;
            tick();
            if (e >= 13) begin
                check($sformatf("dc_i[edge %0d]", e), int'(out_i), 8191);
                check($sformatf("dc_q[edge %0d]", e), int'(out_q), -8192);
                check($sformatf("dc_valid[edge %0d]", e), int'(out_valid), 1);
            end
        end

        // fs/2 on I and fs/4 on Q land in the boxcar nulls.
        apply_reset();
        for (int e = 1; e <= 24; e++) begin
            in_i = (e % 2 == 1) ? 14'sd4000 : -14'sd4000;
            case ((e - 1) % 4)
                0:       in_q = 14'sd4000;
                2:       in_q = -14'sd4000;
                default: in_q = 14'sd0;
            endcase
            tick();
            if (e >= 13) begin
                check($sformatf("null_i[edge %0d]", e), int'(out_i), 0);
                check($sformatf("null_q[edge %0d]", e), int'(out_q), 0);
            end
        end

        // Mid-stream asynchronous reset between edges.
        for (int j = 0; j < 5; j++) begin
            in_i = 14'($urandom_range(16383, 0));
            in_q = 14'($urandom_range(16383, 0));
            tick();
        end
        check("pre_mid_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_i", int'(out_i), 0);
        check("mid_rst_q", int'(out_q), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            in_i = 14'($urandom_range(16383, 0));
            in_q = 14'($urandom_range(16383, 0));
            tick();
            check($sformatf("refill_valid[edge %0d]", e), int'(out_valid), (e >= 13) ? 1 : 0);
        end

`ifdef AA_BYPASS_EN
        // Bypass ramp delayed by 7 edges, then the filtered ramp which lags 10 edges.
        apply_reset();
        bypass = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            in_i = 14'(e - 1);
            in_q = 14'(-(e - 1));
            tick();
            exp = (e >= 7) ? e - 7 : 0;
            check($sformatf("byp_i[edge %0d]", e), int'(out_i), exp);
            check($sformatf("byp_q[edge %0d]", e), int'(out_q), -exp);
            check($sformatf("byp_valid[edge %0d]", e), int'(out_valid), (e >= 13) ? 1 : 0);
        end
        bypass = 1'b0;
        for (int e = 21; e <= 25; e++) begin
            in_i = 14'(e - 1);
            in_q = 14'(-(e - 1));
            tick();
            check($sformatf("filt_ramp_i[edge %0d]", e), int'(out_i), e - 10);
            check($sformatf("filt_ramp_q[edge %0d]", e), int'(out_q), -(e - 10));
            check($sformatf("filt_ramp_valid[edge %0d]", e), int'(out_valid), 1);
        end
`endif

        check("sat_never_hit", int'(sat_seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
